// File: rtl/hdb3_pkg.sv
// Shared definitions for the HDB3 transmit scheduler: FSM encoding, byte
// width and the PRBS-7 constants used for the optional idle pattern.
package hdb3_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // PRBS-7, x^7 + x^6 + 1, Fibonacci form shifting towards the MSB
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'h60;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/hdb3_rr_arb.sv
// Combinational round-robin arbiter: grants the first request found after
// the pointer, wrapping around. The pointer itself lives in the caller.
module hdb3_rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [2:0]       o_idx,
  output logic             o_any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  int                 first;
  int                 sum;

  // Rotate requests so the channel after the pointer sits at bit 0, then pick the lowest set bit
  always_comb begin
    req_dbl = {i_req, i_req};
    req_rot = N_REQ'(req_dbl >> ({1'b0, i_ptr} + 4'd1));
    first   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) first = i;
    end
    sum   = (int'(i_ptr) + 1 + first) % N_REQ;
    o_any = |i_req;
    o_idx = 3'(sum);
    o_gnt = o_any ? (N_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/hdb3_tx_sched.sv
// Round-robin byte scheduler feeding a shared HDB3 encoder chain. Bytes are
// serialised MSB-first with no gap between back-to-back bytes, and a channel
// tag is delayed to line up with the encoder output.
// Define HDB3_TX_PRBS_IDLE_EN to fill idle cycles with PRBS-7 instead of a
// constant idle bit.
module hdb3_tx_sched
  import hdb3_pkg::*;
#(
  parameter int   N_REQ    = 4,
  parameter int   ENC_LAT  = 3,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [BYTE_W*N_REQ-1:0] i_byte,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_data,
  output logic                    o_data_vld,
  output logic [2:0]              o_bit_ch,
  output logic                    o_tag_vld,
  output logic [2:0]              o_tag_ch,
  output logic                    o_busy
);

`ifdef HDB3_TX_PRBS_IDLE_EN
  localparam logic RST_DATA = PRBS7_SEED[6];
`else
  localparam logic RST_DATA = IDLE_BIT;
`endif

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   sr_q, sr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                data_q, data_d;
  logic                vld_q, vld_d;
  logic [2:0]          ch_q, ch_d;
  logic                busy_q, busy_d;
  logic [3:0]          tag_q [ENC_LAT];
  logic [3:0]          tag_d [ENC_LAT];

  logic [N_REQ-1:0]    gnt;
  logic [2:0]          gnt_idx;
  logic                gnt_any;
  logic [BYTE_W-1:0]   sel_byte;
  logic                idle_bit;

  hdb3_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_gnt (gnt),
    .o_idx (gnt_idx),
    .o_any (gnt_any)
  );

  // Pick the byte belonging to the granted channel
  always_comb begin
    sel_byte = '0;
    for (int c = 0; c < N_REQ; c++) begin
      if (gnt[c]) sel_byte = i_byte[c*BYTE_W +: BYTE_W];
    end
  end

`ifdef HDB3_TX_PRBS_IDLE_EN
  logic [6:0] lfsr_q, lfsr_d;

  // The LFSR steps only after an idle cycle, so payload pauses the idle sequence
  always_comb begin
    lfsr_d   = vld_q ? lfsr_q : prbs7_next(lfsr_q);
    idle_bit = lfsr_d[6];
  end

  // LFSR state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lfsr_q <= PRBS7_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign idle_bit = IDLE_BIT;
`endif

  // Next-state logic: shift the current byte, or arbitrate when idle or on its last bit
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    data_d  = idle_bit;
    vld_d   = 1'b0;
    ch_d    = ch_q;
    busy_d  = 1'b0;
    if (state_q == ST_SHIFT && cnt_q != 3'd0) begin
      sr_d   = sr_q << 1;
      cnt_d  = cnt_q - 3'd1;
      data_d = sr_q[BYTE_W-2];
      vld_d  = 1'b1;
      busy_d = 1'b1;
    end else if (gnt_any) begin
      state_d = ST_SHIFT;
      sr_d    = sel_byte;
      cnt_d   = 3'd7;
      ptr_d   = gnt_idx;
      ack_d   = gnt;
      data_d  = sel_byte[BYTE_W-1];
      vld_d   = 1'b1;
      ch_d    = gnt_idx;
      busy_d  = 1'b1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Tag delay line advances every cycle behind the registered bit outputs
  always_comb begin
    tag_d[0] = {vld_q, ch_q};
    for (int i = 1; i < ENC_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // State and output registers; the pointer resets so channel 0 wins first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= 3'(N_REQ - 1);
      ack_q   <= '0;
      data_q  <= RST_DATA;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < ENC_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      for (int i = 0; i < ENC_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign o_ack      = ack_q;
  assign o_data     = data_q;
  assign o_data_vld = vld_q;
  assign o_bit_ch   = ch_q;
  assign o_busy     = busy_q;
  assign o_tag_vld  = tag_q[ENC_LAT-1][3];
  assign o_tag_ch   = tag_q[ENC_LAT-1][2:0];

endmodule

// File: doc/hdb3_tx_sched.md
Name: hdb3_tx_sched

Overview:
- Round-robin scheduler that shares one HDB3 encoder chain (plug-V, plug-B, dual-to-ternary) between N_REQ byte-wide requesters.
- Accepts whole bytes, serialises them MSB-first onto the encoder's single-bit data input, and fills gaps with an idle stream.
- Carries a channel tag through a delay line matched to encoder latency, so downstream logic knows which requester owns each HDB3 symbol.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ENC_LAT, 3, clock cycles from o_data to the matching symbol on the encoder output (≥1).
- IDLE_BIT, 1'b0, bit driven on o_data when no byte is in flight.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req  in  N_REQ  per-channel request; held until o_ack.
- i_byte  in  8*N_REQ  channel c byte at [8c+7:8c]; stable while i_req[c]=1.
- o_ack  out  N_REQ  one-cycle pulse: byte of that channel accepted.
- o_data  out  1  serial bit to encoder i_data.
- o_data_vld  out  1  o_data carries payload (not idle).
- o_bit_ch  out  3  channel owning o_data (valid when o_data_vld).
- o_tag_vld  out  1  o_data_vld delayed ENC_LAT cycles.
- o_tag_ch  out  3  o_bit_ch delayed ENC_LAT cycles.
- o_busy  out  1  byte in flight.

Behaviour:
- All outputs registered.
- Reset values: o_ack=0, o_data=IDLE_BIT, o_data_vld=0, o_bit_ch=0, o_busy=0, tag line all 0, shift register 0, bit counter 0, RR pointer=N_REQ-1 (ch0 has first priority), FSM=IDLE.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If any i_req, arbitrate at the clock edge: the grant is the first set request searching from pointer+1 with wrap.
  - On the grant edge: load the shift register with the byte, set counter=7, update pointer to the grant, and go to SHIFT.
  - In the cycle after that edge: o_ack[g]=1, o_data=bit7, o_data_vld=1, o_bit_ch=g, o_busy=1.
  - With no request, stay in IDLE: o_data=IDLE_BIT, o_data_vld=0.
- SHIFT:
  - Each edge shifts left and decrements the counter; bits 6..0 follow bit7 on consecutive cycles.
  - In the cycle presenting bit0 (counter=0), arbitrate again.
  - If a request is present, load the next byte with no gap; its bit7 and o_ack appear in the following cycle.
  - Otherwise return to IDLE.
- Throughput: 100%; one byte every 8 cycles when requests are continuous. Ack-to-ack minimum is 8 cycles.
- Requests are sampled only at arbitration edges. A request raised mid-byte waits. A request dropped before its grant is simply skipped; no ack is issued.
- Simultaneous requests are resolved by round-robin only; no starvation (worst wait (N_REQ-1)*8+8 cycles).
- Tag line: ENC_LAT-stage shift of {o_data_vld, o_bit_ch}, advancing every cycle.
- Reset mid-byte:
  - The byte in flight is lost; no re-ack.
  - Outputs return to reset values asynchronously.
  - The requester must re-present the byte after reset release.

Optional Feature:
- Macro: HDB3_TX_PRBS_IDLE_EN.
- With the macro defined:
  - Idle cycles drive a PRBS-7 bit (x^7+x^6+1, seed 7'h7F at reset).
  - The LFSR advances only in cycles where o_data_vld=0 and holds during payload, so the idle sequence resumes where it stopped.
- Without the macro: idle drives constant IDLE_BIT and no LFSR is instantiated.

Decomposition:
- Shared package/header hdb3_pkg holds:
  - FSM state encodings (IDLE, SHIFT).
  - BYTE_W=8.
  - PRBS-7 seed and tap constants.
- One sub-module: hdb3_rr_arb, the N_REQ round-robin arbiter.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational; the pointer register stays in hdb3_tx_sched.

Test Plan:
- Single request, ch2, i_byte=8'hA5 → o_ack[2] one cycle after the sampling edge. o_data=1,0,1,0,0,1,0,1 over 8 cycles with o_data_vld=1 and o_bit_ch=2, then IDLE_BIT with vld=0.
- All four i_req high from reset release with distinct bytes → grants ch0,1,2,3 in order. Acks exactly 8 cycles apart and o_data_vld continuous for 32 cycles.
- ch0 and ch1 held high continuously → grant order 0,1,0,1,... with no gaps and no repeated grant while the other requests.
- i_rst pulsed after 3 bits of ch1 byte 8'hFF:
  - During reset, outputs go to reset values immediately.
  - After release with ch1 and ch3 requesting, ch1 is granted first (pointer reset), and a full fresh byte is sent.
- ENC_LAT=3, ch3 byte → o_tag_vld high for exactly 8 cycles starting 3 cycles after o_data_vld rises, with o_tag_ch=3.
- HDB3_TX_PRBS_IDLE_EN defined:
  - 254 idle cycles → idle bitstream periodic with period 127, matching the reference LFSR from seed 7'h7F.
  - After inserting one byte, the idle stream continues from the held LFSR state.
